// File: rtl/calc_pkg.sv
// calc_pkg: constants and types shared by the calculator pipeline.
//
// Contents:
//   OP_W, RES_W, CMD_W  - operand, result and command code widths
//   CMD_ADD .. CMD_MOD  - command codes. Each one is the low nibble of the
//                         ASCII character for that operator.
//   ITER_STEPS          - number of steps in the multiplier/divider sequences
//   exec_state_t        - state encoding for the execution stage FSM
//   cmd_is_iterative()  - tells whether a command runs the 8-step sequence
//
// Configuration macro: CALC_EXEC_MUL_EN. When it is undefined, MUL is not
// treated as an iterative command. The execution stage then rejects it as
// an invalid cmd.

package calc_pkg;

  localparam int OP_W  = 8;
  localparam int RES_W = 16;
  localparam int CMD_W = 4;

  localparam int ITER_STEPS = OP_W;

  localparam logic [CMD_W-1:0] CMD_ADD = 4'hB;  // '+'
  localparam logic [CMD_W-1:0] CMD_SUB = 4'hD;  // '-'
  localparam logic [CMD_W-1:0] CMD_MUL = 4'hA;  // '*'
  localparam logic [CMD_W-1:0] CMD_DIV = 4'hF;  // '/'
  localparam logic [CMD_W-1:0] CMD_MOD = 4'h5;  // '%'

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_ITER = 2'd2
  } exec_state_t;

  // A command runs the 8-step sequence only when it can produce a valid
  // result. DIV or MOD by zero goes through the one-cycle error path.
  function automatic logic cmd_is_iterative(input logic [CMD_W-1:0] cmd,
                                            input logic [OP_W-1:0]  divisor);
    logic iter;
    iter = 1'b0;
    if ((cmd == CMD_DIV || cmd == CMD_MOD) && divisor != '0)
      iter = 1'b1;
`ifdef CALC_EXEC_MUL_EN
    if (cmd == CMD_MUL)
      iter = 1'b1;
`endif
    return iter;
  endfunction

endpackage

// File: rtl/calc_exec_div.sv
// calc_exec_div: iterative restoring divider for the calculator.
//
// The parent FSM sequences this block. It pulses 'load' to capture the
// operands. It then holds 'step' high for OP_W cycles. Each step retires
// one quotient bit, starting from the MSB.
//
// The quotient and remainder outputs are combinational. They show the
// values the internal registers will hold after the current step. During
// the final step they are therefore already the finished result, so the
// parent can capture them on that same edge without an extra cycle.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   load       - capture dividend/divisor and clear the partial remainder
//   step       - perform one restoring-division step
//   dividend   - unsigned dividend (operand A)
//   divisor    - unsigned divisor (operand B); must be nonzero when stepping
//   quotient   - quotient after the current step
//   remainder  - partial remainder after the current step

module calc_exec_div
  import calc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [OP_W-1:0] dividend,
  input  logic [OP_W-1:0] divisor,
  output logic [OP_W-1:0] quotient,
  output logic [OP_W-1:0] remainder
);

  // quo_q starts out holding the dividend. Each step shifts it left.
  // The low end fills with quotient bits while the high end feeds
  // dividend bits into the partial remainder.
  logic [OP_W-1:0] quo_q;
  logic [OP_W-1:0] rem_q;
  logic [OP_W-1:0] dsr_q;

  logic [OP_W:0]   shifted;
  logic [OP_W+1:0] trial;

  // The trial subtraction gets one spare bit above the shifted remainder.
  // Its top bit is then a clean borrow flag.
  always_comb begin
    shifted   = {rem_q, quo_q[OP_W-1]};
    trial     = {1'b0, shifted} - {2'b00, dsr_q};
    quotient  = {quo_q[OP_W-2:0], 1'b0};
    remainder = shifted[OP_W-1:0];
    if (!trial[OP_W+1]) begin
      quotient  = {quo_q[OP_W-2:0], 1'b1};
      remainder = trial[OP_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dsr_q <= divisor;
    end else if (step) begin
      quo_q <= quotient;
      rem_q <= remainder;
    end
  end

endmodule

// File: rtl/calc_exec.sv
// calc_exec: arithmetic execution stage of the calculator.
//
// The stage accepts a one-cycle start pulse from the command interpreter.
// It samples op_A, op_B and cmd at that point. It then produces a
// registered result together with the flags and a one-cycle done pulse.
//   - ADD, SUB and all error cases take the one-cycle CALC state
//     (latency 2).
//   - MUL, DIV and MOD run an 8-step ITER sequence (latency 9).
//   - A start pulse that arrives while busy is dropped.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   start     - request pulse (interpreter rdy)
//   op_A      - operand A, unsigned
//   op_B      - operand B, unsigned
//   cmd       - operation code (see calc_pkg)
//   result    - unsigned magnitude of the last result, held until the
//               next completion
//   neg       - last result is negative (SUB only)
//   err       - last operation was invalid
//   done      - one-cycle completion pulse
//   busy      - an accepted operation is in progress
//
// Configuration macro: CALC_EXEC_MUL_EN. When it is defined, MUL runs on
// the inline shift-add multiplier. When it is undefined, the multiplier is
// absent and 4'hA completes with err=1 like any other unknown cmd.

module calc_exec
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  op_A,
  input  logic [OP_W-1:0]  op_B,
  input  logic [CMD_W-1:0] cmd,
  output logic [RES_W-1:0] result,
  output logic             neg,
  output logic             err,
  output logic             done,
  output logic             busy
);

  exec_state_t      state;
  logic [2:0]       step_cnt;
  logic [OP_W-1:0]  a_q;
  logic [OP_W-1:0]  b_q;
  logic [CMD_W-1:0] cmd_q;

  logic             accept;
  logic             iter_step;
  logic             last_step;
  logic [OP_W-1:0]  div_quotient;
  logic [OP_W-1:0]  div_remainder;

  // Starts are taken only in IDLE. That includes the cycle in which done
  // is high, because the FSM is already back in IDLE by then.
  assign accept    = (state == ST_IDLE) && start;
  assign iter_step = (state == ST_ITER);
  assign last_step = iter_step && (step_cnt == 3'(ITER_STEPS - 1));

  calc_exec_div u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (iter_step),
    .dividend  (op_A),
    .divisor   (op_B),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

`ifdef CALC_EXEC_MUL_EN
  // Shift-add multiplier. Each step adds the current multiplicand when
  // the LSB of the shifted multiplier is set. mul_acc_next is the sum
  // including the current step, so the final product is available during
  // the last step.
  logic [RES_W-1:0] mul_acc;
  logic [RES_W-1:0] mul_mcand;
  logic [OP_W-1:0]  mul_mplier;
  logic [RES_W-1:0] mul_acc_next;

  assign mul_acc_next = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
    end else if (accept) begin
      mul_acc    <= '0;
      mul_mcand  <= RES_W'(op_A);
      mul_mplier <= op_B;
    end else if (iter_step) begin
      mul_acc    <= mul_acc_next;
      mul_mcand  <= {mul_mcand[RES_W-2:0], 1'b0};
      mul_mplier <= {1'b0, mul_mplier[OP_W-1:1]};
    end
  end
`endif

  // Control FSM with registered outputs. done defaults low every cycle,
  // so it can only be high for a single cycle. Reset has priority over
  // start and discards any operation in progress without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      step_cnt <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cmd_q    <= '0;
      result   <= '0;
      neg      <= 1'b0;
      err      <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q      <= op_A;
            b_q      <= op_B;
            cmd_q    <= cmd;
            busy     <= 1'b1;
            step_cnt <= '0;
            if (cmd_is_iterative(cmd, op_B))
              state <= ST_ITER;
            else
              state <= ST_CALC;
          end
        end

        // Only ADD, SUB and the error cases ever reach CALC. Everything
        // that is neither ADD nor SUB is therefore an error completion.
        ST_CALC: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
          neg   <= 1'b0;
          err   <= 1'b0;
          case (cmd_q)
            CMD_ADD: result <= RES_W'(a_q) + RES_W'(b_q);
            CMD_SUB: begin
              if (a_q >= b_q) begin
                result <= RES_W'(a_q - b_q);
              end else begin
                result <= RES_W'(b_q - a_q);
                neg    <= 1'b1;
              end
            end
            default: begin
              result <= '0;
              err    <= 1'b1;
            end
          endcase
        end

        ST_ITER: begin
          step_cnt <= step_cnt + 3'd1;
          if (last_step) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
            step_cnt <= '0;
            neg      <= 1'b0;
            err      <= 1'b0;
            case (cmd_q)
              CMD_DIV: result <= RES_W'(div_quotient);
              CMD_MOD: result <= RES_W'(div_remainder);
`ifdef CALC_EXEC_MUL_EN
              CMD_MUL: result <= mul_acc_next;
`endif
              default: result <= '0;
            endcase
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_exec.sv
// tb_calc_exec: self-checking bench for calc_exec.
//
// A reference model tracks operations at the transaction level. For each
// accepted operation it computes the result with plain arithmetic and
// schedules the cycle in which that result must appear. A compare process
// checks all outputs against the model on every falling edge. The
// directed sequences also check hand-computed literal values and
// latencies.
//
// The CALC_EXEC_MUL_EN macro selects which MUL expectations apply.

module tb_calc_exec;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  op_A;
  logic [7:0]  op_B;
  logic [3:0]  cmd;
  logic [15:0] result;
  logic        neg;
  logic        err;
  logic        done;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef CALC_EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  calc_exec dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_A   (op_A),
    .op_B   (op_B),
    .cmd    (cmd),
    .result (result),
    .neg    (neg),
    .err    (err),
    .done   (done),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int unsigned actual,
                             input int unsigned expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Transaction-level reference: result, flags and latency of a command.
  function automatic void model_op(input logic [7:0] a, input logic [7:0] b,
                                   input logic [3:0] c, output int res,
                                   output bit n, output bit e, output int lat);
    res = 0; n = 1'b0; e = 1'b0; lat = 2;
    if (c == 4'hB) res = int'(a) + int'(b);
    else if (c == 4'hD) begin
      if (a >= b) res = int'(a) - int'(b);
      else begin res = int'(b) - int'(a); n = 1'b1; end
    end
    else if (c == 4'hA && MUL_EN) begin res = int'(a) * int'(b); lat = 9; end
    else if ((c == 4'hF || c == 4'h5) && b != 0) begin
      res = (c == 4'hF) ? int'(a) / int'(b) : int'(a) % int'(b);
      lat = 9;
    end
    else e = 1'b1;
  endfunction

  // Model state. An operation accepted at edge E with latency L completes
  // at edge E+L-1. The stage counts as idle again at the edge after that.
  int cyc = 0;
  bit model_ready = 1'b0;
  bit pend_valid = 1'b0;
  int pend_done_cyc, pend_res;
  bit pend_neg, pend_err;
  int exp_result = 0;
  bit exp_neg = 0, exp_err = 0, exp_done = 0, exp_busy = 0;

  always @(posedge clk) begin
    int r, l;
    bit n, e, idle_now;
    cyc++;
    if (rst) begin
      model_ready = 1'b1;
      pend_valid = 1'b0;
      exp_result = 0; exp_neg = 0; exp_err = 0; exp_done = 0; exp_busy = 0;
    end else begin
      idle_now = !pend_valid;
      exp_done = 1'b0;
      if (pend_valid && cyc == pend_done_cyc) begin
        exp_result = pend_res; exp_neg = pend_neg; exp_err = pend_err;
        exp_done = 1'b1;
        pend_valid = 1'b0;
      end
      if (start && idle_now) begin
        model_op(op_A, op_B, cmd, r, n, e, l);
        pend_valid = 1'b1;
        pend_done_cyc = cyc + l - 1;
        pend_res = r; pend_neg = n; pend_err = e;
      end
      exp_busy = pend_valid;
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("cyc_result", result, exp_result);
      checkOutput("cyc_neg", neg, exp_neg);
      checkOutput("cyc_err", err, exp_err);
      checkOutput("cyc_done", done, exp_done);
      checkOutput("cyc_busy", busy, exp_busy);
    end
  end

  // Issues one operation and waits for done. It then checks the latency
  // and the literal result values. It returns #1 after the edge that
  // raised done, so a following call starts in the done cycle.
  task automatic applyStimulus(input string name, input logic [7:0] a,
                               input logic [7:0] b, input logic [3:0] c,
                               input int exp_lat, input int exp_res,
                               input bit exp_n, input bit exp_e);
    int lat;
    op_A = a; op_B = b; cmd = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_A = 8'h00; op_B = 8'h00; cmd = 4'h0;
    lat = 1;
    checkOutput({name, "_busy_c1"}, busy, 1);
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) checkOutput({name, "_timeout"}, 0, 1);
    checkOutput({name, "_latency"}, lat, exp_lat);
    checkOutput({name, "_result"}, result, exp_res);
    checkOutput({name, "_neg"}, neg, exp_n);
    checkOutput({name, "_err"}, err, exp_e);
  endtask

  initial begin
    int n_done;
    rst = 1'b1; start = 1'b0; op_A = '0; op_B = '0; cmd = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_result", result, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_err", err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus("add", 8'd25, 8'd17, 4'hB, 2, 42, 0, 0);
    @(posedge clk); #1;
    checkOutput("add_done_once", done, 0);
    applyStimulus("sub_neg", 8'd7, 8'd200, 4'hD, 2, 193, 1, 0);
    applyStimulus("sub_pos", 8'd200, 8'd7, 4'hD, 2, 193, 0, 0);
    if (MUL_EN) begin
      applyStimulus("mul_max", 8'd255, 8'd255, 4'hA, 9, 65025, 0, 0);
      applyStimulus("mul_3x4", 8'd3, 8'd4, 4'hA, 9, 12, 0, 0);
    end else begin
      applyStimulus("mul_off", 8'd3, 8'd4, 4'hA, 2, 0, 0, 1);
      applyStimulus("mul_off_max", 8'd255, 8'd255, 4'hA, 2, 0, 0, 1);
    end
    applyStimulus("div", 8'd99, 8'd7, 4'hF, 9, 14, 0, 0);
    applyStimulus("mod", 8'd99, 8'd7, 4'h5, 9, 1, 0, 0);
    applyStimulus("div_zero", 8'd99, 8'd0, 4'hF, 2, 0, 0, 1);
    applyStimulus("div_big", 8'd200, 8'd13, 4'hF, 9, 15, 0, 0);
    applyStimulus("mod_zero", 8'd5, 8'd0, 4'h5, 2, 0, 0, 1);
    applyStimulus("div_by_one", 8'd255, 8'd1, 4'hF, 9, 255, 0, 0);
    applyStimulus("mod_small", 8'd3, 8'd200, 4'h5, 9, 3, 0, 0);
    applyStimulus("add_max", 8'd255, 8'd255, 4'hB, 2, 510, 0, 0);

    // A start pulse during an iterative operation must be dropped.
    op_A = 8'd200; op_B = 8'd3; cmd = 4'hF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    op_A = 8'd1; op_B = 8'd1; cmd = 4'hB; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    checkOutput("drop_done_count", n_done, 1);
    checkOutput("drop_result", result, 66);

    applyStimulus("bad_cmd", 8'd9, 8'd9, 4'h3, 2, 0, 0, 1);

    // Reset in cycle 5 of a DIV clears everything and suppresses done.
    op_A = 8'd99; op_B = 8'd7; cmd = 4'hF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    op_A = 8'd1; op_B = 8'd2; cmd = 4'hB; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    checkOutput("rst_err", err, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) n_done++;
    end
    checkOutput("rst_no_done", n_done, 0);

    applyStimulus("after_rst", 8'd10, 8'd20, 4'hD, 2, 10, 1, 0);
    applyStimulus("mod_after", 8'd250, 8'd16, 4'h5, 9, 10, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
